alu_arbiter: RTL and testbench

Shares one `alu` instance among `NREQ` requesters. Requests use a valid/ready handshake and are arbitrated round-robin. Operands are latched and executed with a registered result. Each result is returned through a single response port, tagged with the requester ID and the flags `{z,n,c,v}`. The block sits between the issue stages of the datapath clients and the shared ALU and holds at most one operation in flight.

---
 rtl/alu_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters.
//
// Requesters present op/a/b with req_valid and are granted round-robin.
// The granted operation is latched, executed on the shared ALU, and its
// registered result is returned on a single response port tagged with
// the requester index. At most one operation is in flight.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[NREQ]     per-requester request valid
//   req_ready[NREQ]     per-requester accept (one-hot or zero)
//   req_op[3*NREQ]      packed opcodes, requester i at [3i+2:3i]
//   req_a/req_b         packed 32-bit operands, requester i at [32i+31:32i]
//   rsp_valid/ready     response handshake
//   rsp_id              index of the requester that issued the operation
//   rsp_y, rsp_flags    registered ALU result and {z,n,c,v}
//   rsp_err             opcode was 110 or 111

// Combinational 32-bit ALU. For SUB the carry is the carry-out of
// a + ~b + 1, so c=1 means "no borrow". Illegal opcodes give y=0,
// which naturally yields flags 4'b1000.
module alu (
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic [3:0]  flags
);
    logic [32:0] sum;
    logic        c;
    logic        v;

    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            3'b000: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[31:0];
                c   = sum[32];
                v   = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            3'b001: begin
                sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
                y   = sum[31:0];
                c   = sum[32];
                v   = (a[31] != b[31]) && (sum[31] != a[31]);
            end
            3'b010:  y = a & b;
            3'b011:  y = a | b;
            3'b100:  y = a ^ b;
            3'b101:  y = {31'd0, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
        flags = {(y == 32'd0), y[31], c, v};
    end
endmodule

module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_y,
    output logic [3:0]           rsp_flags,
    output logic                 rsp_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [IDW-1:0] last;
    logic [IDW-1:0] grant_id;
    logic           any_valid;
    logic           grant;

    logic [2:0]     sel_op;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;

    logic [2:0]     op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [IDW-1:0] id_q;

    logic [31:0]    alu_y;
    logic [3:0]     alu_flags;

    // Round-robin pick: the first set valid bit scanning upward from
    // last+1 with wrap-around. The outer loop walks priority order, the
    // inner loop matches that position without variable bit-selects.
    always_comb begin
        any_valid = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!any_valid && req_valid[j] && (j == (int'(last) + 1 + i) % NREQ)) begin
                    any_valid = 1'b1;
                    grant_id  = IDW'(j);
                end
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_id == IDW'(j)) begin
                sel_op = req_op[3*j +: 3];
                sel_a  = req_a[32*j +: 32];
                sel_b  = req_b[32*j +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // rst_n gates the grant so req_ready reads 0 for the whole reset
    // interval even while requesters keep req_valid high.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (any_valid && rst_n) begin
                    grant      = 1'b1;
                    next_state = EXEC;
                    for (int j = 0; j < NREQ; j++) begin
                        if (grant_id == IDW'(j)) begin
                            req_ready[j] = 1'b1;
                        end
                    end
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    alu u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .flags (alu_flags)
    );

    // Operand latch, round-robin pointer and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            last      <= IDW'(NREQ - 1);
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (grant) begin
                op_q <= sel_op;
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= grant_id;
                last <= grant_id;
            end
            if (state == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_q;
                rsp_y     <= alu_y;
                rsp_flags <= alu_flags;
                rsp_err   <= (op_q == 3'b110) || (op_q == 3'b111);
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios followed by a randomized run, all
// checked against a transaction-level model (round-robin pick computed by
// scanning the pending set, ALU results computed with wide arithmetic).
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic        err;
        logic [3:0]  flags;
        logic [31:0] y;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [3*NREQ-1:0]   req_op;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_y;
    logic [3:0]          rsp_flags;
    logic                rsp_err;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side stimulus state
    bit [NREQ-1:0] pend;
    bit [2:0]      op_arr [NREQ];
    bit [31:0]     a_arr  [NREQ];
    bit [31:0]     b_arr  [NREQ];
    int            refill_pct = 0;
    int            rdy_pct    = 100;

    // Model state
    bit            busy;
    int            age;
    int            last_m;
    exp_t          expd;
    int            eid;
    int            cycle = 0;

    // Observations recorded at the sampling point
    int            grant_log [$];
    int            rsp_cycles [$];
    logic [NREQ-1:0] ready_seen;
    logic          snap_valid;
    logic [IDW-1:0] snap_id;
    logic [31:0]   snap_y;
    logic [3:0]    snap_flags;
    logic          snap_err;

    function automatic exp_t refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        longint ua, ub, sa, sb, s;
        logic   c, v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        r.err = 1'b0;
        r.y = '0;
        case (op)
            3'd0: begin
                r.y = a + b;
                c = ((ua + ub) > 64'sd4294967295);
                s = sa + sb;
                v = (s > SMAX) || (s < SMIN);
            end
            3'd1: begin
                r.y = a - b;
                c = (ua >= ub);
                s = sa - sb;
                v = (s > SMAX) || (s < SMIN);
            end
            3'd2: r.y = a & b;
            3'd3: r.y = a | b;
            3'd4: r.y = a ^ b;
            3'd5: r.y = (sa < sb) ? 32'd1 : 32'd0;
            default: r.err = 1'b1;
        endcase
        r.flags = {(r.y == 32'd0), r.y[31], c, v};
        return r;
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(5))
            0: return 32'd0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(7));
            default: return $urandom();
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        pend[i]   = 1'b1;
        op_arr[i] = op;
        a_arr[i]  = a;
        b_arr[i]  = b;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(99) < refill_pct) begin
                setReq(i, 3'($urandom_range(7)), randOperand(), randOperand());
            end
            req_op[3*i +: 3]  = op_arr[i];
            req_a[32*i +: 32] = a_arr[i];
            req_b[32*i +: 32] = b_arr[i];
        end
        req_valid = pend;
        rsp_ready = ($urandom_range(99) < rdy_pct);
    endtask

    // Sampled at the falling edge: compare against the model, then advance it.
    task automatic modelCycle();
        logic [NREQ-1:0] exp_ready;
        int pick;
        ready_seen = req_ready;
        snap_valid = rsp_valid;
        snap_id    = rsp_id;
        snap_y     = rsp_y;
        snap_flags = rsp_flags;
        snap_err   = rsp_err;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) grant_log.push_back(i);
        end
        if (rsp_valid && rsp_ready) rsp_cycles.push_back(cycle);
        exp_ready = '0;
        if (!busy) begin
            pick = -1;
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (last_m + 1 + i) % NREQ;
                if (pick < 0 && pend[c]) pick = c;
            end
            if (pick >= 0) exp_ready[pick] = 1'b1;
            checkOutput("req_ready_idle", 64'(req_ready), 64'(exp_ready));
            checkOutput("rsp_valid_idle", 64'(rsp_valid), 64'd0);
            if (pick >= 0) begin
                expd   = refModel(op_arr[pick], a_arr[pick], b_arr[pick]);
                eid    = pick;
                busy   = 1'b1;
                age    = 0;
                last_m = pick;
                pend[pick] = 1'b0;
            end
        end else begin
            age++;
            checkOutput("req_ready_busy", 64'(req_ready), 64'd0);
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(age >= 2));
            if (age >= 2) begin
                checkOutput("rsp_id", 64'(rsp_id), 64'(eid));
                checkOutput("rsp_y", 64'(rsp_y), 64'(expd.y));
                checkOutput("rsp_flags", 64'(rsp_flags), 64'(expd.flags));
                checkOutput("rsp_err", 64'(rsp_err), 64'(expd.err));
                if (rsp_ready) busy = 1'b0;
            end
        end
        cycle++;
    endtask

    // Each step starts and ends 1 time unit after a rising edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus();
            @(negedge clk);
            modelCycle();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        checkOutput({tag, "_rsp_y"}, 64'(rsp_y), 64'd0);
        checkOutput({tag, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
        checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    endtask

    // Asserts reset with every requester valid; outputs must clear at once.
    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        #1;
        checkResetOutputs("reset_async");
        busy   = 1'b0;
        last_m = NREQ - 1;
        pend   = '0;
        @(negedge clk);
        checkResetOutputs("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rr_exp [6];
        rr_exp = '{0, 1, 2, 3, 0, 1};
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i] = '0;
            a_arr[i]  = '0;
            b_arr[i]  = '0;
        end
        @(posedge clk);
        #1;

        $display("[TB] reset with all requesters valid");
        doReset();
        for (int i = 0; i < NREQ; i++) setReq(i, 3'd0, 32'(i), 32'd1);
        refill_pct = 0;
        rdy_pct    = 100;
        step(1);
        checkOutput("first_grant", 64'(ready_seen), 64'h1);

        $display("[TB] single ADD with overflow");
        doReset();
        setReq(2, 3'd0, 32'h7FFF_FFFF, 32'd1);
        step(1);
        checkOutput("add_grant", 64'(ready_seen), 64'h4);
        step(1);
        checkOutput("add_latency_exec", 64'(snap_valid), 64'd0);
        step(1);
        checkOutput("add_latency_resp", 64'(snap_valid), 64'd1);
        checkOutput("add_id", 64'(snap_id), 64'd2);
        checkOutput("add_y", 64'(snap_y), 64'h8000_0000);
        checkOutput("add_flags", 64'(snap_flags), 64'b0101);

        $display("[TB] round-robin fairness");
        doReset();
        grant_log.delete();
        rsp_cycles.delete();
        refill_pct = 100;
        step(18);
        checkOutput("rr_count", 64'(grant_log.size() >= 6), 64'd1);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
            checkOutput("rr_order", 64'(grant_log[k]), 64'(rr_exp[k]));
        end
        for (int k = 1; k < 5 && k < rsp_cycles.size(); k++) begin
            checkOutput("rr_spacing", 64'(rsp_cycles[k] - rsp_cycles[k-1]), 64'd3);
        end

        $display("[TB] backpressure on SUB");
        doReset();
        refill_pct = 0;
        setReq(0, 3'd1, 32'd5, 32'd5);
        setReq(1, 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        rdy_pct = 0;
        step(2);
        step(1);
        checkOutput("sub_y", 64'(snap_y), 64'd0);
        checkOutput("sub_flags", 64'(snap_flags), 64'b1010);
        step(9);
        checkOutput("bp_ready_held", 64'(ready_seen), 64'd0);
        rdy_pct = 100;
        step(1);
        step(1);
        checkOutput("bp_next_grant", 64'(ready_seen), 64'h2);
        step(2);

        $display("[TB] illegal opcode and SLT");
        doReset();
        setReq(1, 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
        step(3);
        checkOutput("ill_err", 64'(snap_err), 64'd1);
        checkOutput("ill_y", 64'(snap_y), 64'd0);
        checkOutput("ill_flags", 64'(snap_flags), 64'b1000);
        setReq(3, 3'd5, 32'hFFFF_FFFF, 32'd0);
        step(3);
        checkOutput("slt_y", 64'(snap_y), 64'd1);
        checkOutput("slt_err", 64'(snap_err), 64'd0);
        checkOutput("slt_id", 64'(snap_id), 64'd3);

        $display("[TB] reset during execution");
        doReset();
        setReq(1, 3'd0, 32'd10, 32'd20);
        step(1);
        doReset();
        setReq(1, 3'd0, 32'd10, 32'd20);
        setReq(3, 3'd3, 32'd1, 32'd2);
        step(1);
        checkOutput("regrant_after_reset", 64'(ready_seen), 64'h2);
        step(6);

        $display("[TB] randomized traffic");
        doReset();
        refill_pct = 40;
        rdy_pct    = 60;
        step(600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
